// File: rtl/line_buf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : line_buf_pkg
//  Description : Shared types, default sizes and helpers for the multi-row
//                line window buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
package line_buf_pkg;

    localparam int LB_DATA_W    = 64;
    localparam int LB_COORD_W   = 16;
    localparam int LB_MAX_WIDTH = 8192;
    localparam int LB_KH        = 3;
    localparam int NUM_BANKS    = LB_KH - 1;

    typedef logic [LB_COORD_W-1:0] coord_t;
    typedef logic [LB_DATA_W-1:0]  pixel_t;

    // Row length of 0 or 1 behaves as a single column; anything beyond the
    // physical bank depth is limited to that depth.
    function automatic logic [31:0] clamp_width(input logic [31:0] width,
                                                input logic [31:0] max_width);
        if (width <= 32'd1)
            return 32'd1;
        else if (width > max_width)
            return max_width;
        else
            return width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/line_bank.sv
`default_nettype none
// ============================================================================
//  Module      : line_bank
//  Description : One read-first block-RAM bank holding a single image row.
//                Read data is registered and only updates while en is high.
//  Revision    : 1.0 - initial release
// ============================================================================
module line_bank
    import line_buf_pkg::*;
#(
    parameter int DATA_W = LB_DATA_W,
    parameter int DEPTH  = LB_MAX_WIDTH,
    parameter int ADDR_W = 13
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    (* ram_style = "block" *) logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Read-first port: the old word is returned while the new one is written.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we)
                r_mem[addr] <= wdata;
            r_rdata <= r_mem[addr];
        end
    end

    assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/line_window_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : line_window_buffer
//  Description : KH-row line buffer. Each accepted raster pixel yields one
//                vertical column {row r, r-1, ..., r-KH+1} at the same column
//                one cycle later. Valid/ready on both sides.
//                Optional macro LINE_WINDOW_ZERO_PAD_EN: top-edge zero padding
//                (every pixel produces output, taps above row 0 read as 0).
//  Revision    : 1.0 - initial release
// ============================================================================
module line_window_buffer
    import line_buf_pkg::*;
#(
    parameter int DATA_W    = LB_DATA_W,
    parameter int MAX_WIDTH = LB_MAX_WIDTH,
    parameter int KH        = LB_KH,
    parameter int COORD_W   = LB_COORD_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [COORD_W-1:0]   cfg_width,
    input  logic [COORD_W-1:0]   cfg_height,
    input  logic                 start,
    output logic                 busy,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [DATA_W-1:0]    s_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [KH*DATA_W-1:0] m_data,
    output logic [COORD_W-1:0]   m_col,
    output logic [COORD_W-1:0]   m_row,
    output logic                 m_last
);

    localparam int BANKS  = KH - 1;
    localparam int ADDR_W = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
    localparam int SEL_W  = 3;

    // Frame control state
    logic               r_busy;
    logic [COORD_W-1:0] r_width;
    logic [COORD_W-1:0] r_height;
    logic [COORD_W-1:0] r_col;
    logic [COORD_W-1:0] r_row;
    logic [SEL_W-1:0]   r_sel;

    // Output stage
    logic               r_m_valid;
    logic [DATA_W-1:0]  r_tap0;
    logic [COORD_W-1:0] r_col_o;
    logic [COORD_W-1:0] r_row_o;
    logic               r_last;
    logic [SEL_W-1:0]   r_rot;

    logic                 w_accept;
    logic                 w_emit;
    logic                 w_col_end;
    logic                 w_row_end;
    logic [DATA_W-1:0]    w_rdata [BANKS];
    logic [KH*DATA_W-1:0] w_m_data;
    int                   w_idx;

    // A start pulse owns its cycle, so no pixel can slip in alongside it.
    assign s_ready   = r_busy && (!r_m_valid || m_ready) && !start;
    assign w_accept  = s_valid && s_ready;
    assign w_col_end = (r_col == r_width - COORD_W'(1));
    assign w_row_end = (r_row == r_height - COORD_W'(1));

`ifdef LINE_WINDOW_ZERO_PAD_EN
    assign w_emit = w_accept;
`else
    // The first KH-1 rows only fill the banks.
    assign w_emit = w_accept && (r_row >= COORD_W'(KH - 1));
`endif

    // Config latch, raster counters and bank selection.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy   <= 1'b0;
            r_width  <= COORD_W'(1);
            r_height <= COORD_W'(1);
            r_col    <= '0;
            r_row    <= '0;
            r_sel    <= '0;
        end else if (start) begin
            r_busy   <= 1'b1;
            r_width  <= COORD_W'(clamp_width(32'(cfg_width), 32'(MAX_WIDTH)));
            r_height <= (cfg_height == '0) ? COORD_W'(1) : cfg_height;
            r_col    <= '0;
            r_row    <= '0;
            r_sel    <= '0;
        end else if (w_accept) begin
            if (w_col_end) begin
                r_col <= '0;
                if (w_row_end) begin
                    r_busy <= 1'b0;
                    r_row  <= '0;
                    r_sel  <= '0;
                end else begin
                    r_row <= r_row + COORD_W'(1);
                    r_sel <= (r_sel == SEL_W'(BANKS - 1)) ? '0 : r_sel + SEL_W'(1);
                end
            end else begin
                r_col <= r_col + COORD_W'(1);
            end
        end
    end

    // Output register: loads on accept, holds under backpressure, clears on
    // handshake, and drops any in-flight column on start.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_m_valid <= 1'b0;
            r_tap0    <= '0;
            r_col_o   <= '0;
            r_row_o   <= '0;
            r_last    <= 1'b0;
            r_rot     <= '0;
        end else if (start) begin
            r_m_valid <= 1'b0;
        end else if (w_accept) begin
            r_m_valid <= w_emit;
            r_tap0    <= s_data;
            r_col_o   <= r_col;
            r_row_o   <= r_row;
            r_last    <= w_col_end && w_row_end;
            r_rot     <= r_sel;
        end else if (r_m_valid && m_ready) begin
            r_m_valid <= 1'b0;
        end
    end

    // Banks are read on every accept; only the current row's bank is written.
    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        line_bank #(
            .DATA_W (DATA_W),
            .DEPTH  (MAX_WIDTH),
            .ADDR_W (ADDR_W)
        ) u_bank (
            .clk   (clk),
            .en    (w_accept),
            .we    (w_accept && (r_sel == SEL_W'(b))),
            .addr  (r_col[ADDR_W-1:0]),
            .wdata (s_data),
            .rdata (w_rdata[b])
        );
    end

    // Rotate bank outputs so tap i is row r-i; bank (rot - i) mod BANKS holds
    // it, and i == BANKS lands on the overwritten bank's read-first data.
    always_comb begin
        w_m_data = '0;
        w_idx    = 0;
        if (r_m_valid) begin
            w_m_data[0 +: DATA_W] = r_tap0;
            for (int i = 1; i < KH; i++) begin
                w_idx = (int'(r_rot) >= i) ? int'(r_rot) - i : int'(r_rot) + BANKS - i;
                for (int j = 0; j < BANKS; j++) begin
                    if (w_idx == j)
                        w_m_data[i*DATA_W +: DATA_W] = w_rdata[j];
                end
`ifdef LINE_WINDOW_ZERO_PAD_EN
                if (r_row_o < COORD_W'(i))
                    w_m_data[i*DATA_W +: DATA_W] = '0;
`endif
            end
        end
    end

    assign busy    = r_busy;
    assign m_valid = r_m_valid;
    assign m_data  = w_m_data;
    assign m_col   = r_col_o;
    assign m_row   = r_row_o;
    assign m_last  = r_last;

endmodule
`default_nettype wire

// File: tb/tb_line_window_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_line_window_buffer
//  Description : Self-checking bench for line_window_buffer (KH=3). A model
//                queues the expected column for every accepted pixel and the
//                DUT output is compared against the queue head each cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_line_window_buffer;

    localparam int DW = 16;
    localparam int MW = 64;
    localparam int KH = 3;
    localparam int CW = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [CW-1:0]   cfg_width;
    logic [CW-1:0]   cfg_height;
    logic            start;
    logic            busy;
    logic            s_valid;
    logic            s_ready;
    logic [DW-1:0]   s_data;
    logic            m_valid;
    logic            m_ready;
    logic [KH*DW-1:0] m_data;
    logic [CW-1:0]   m_col;
    logic [CW-1:0]   m_row;
    logic            m_last;

    typedef struct {
        logic [KH*DW-1:0] data;
        int               row;
        int               col;
        logic             last;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    line_window_buffer #(
        .DATA_W    (DW),
        .MAX_WIDTH (MW),
        .KH        (KH),
        .COORD_W   (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_width  (cfg_width),
        .cfg_height (cfg_height),
        .start      (start),
        .busy       (busy),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_col      (m_col),
        .m_row      (m_row),
        .m_last     (m_last)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] pix(input int base, input int r, input int c);
        return DW'(base + r * 16 + c);
    endfunction

    function automatic bit emits(input int r);
`ifdef LINE_WINDOW_ZERO_PAD_EN
        return 1'b1;
`else
        return r >= KH - 1;
`endif
    endfunction

    function automatic exp_t make_exp(input int base, input int r, input int c, input bit last);
        exp_t e;
        e.data = '0;
        for (int i = 0; i < KH; i++)
            if (r - i >= 0)
                e.data[i*DW +: DW] = pix(base, r - i, c);
        e.row  = r;
        e.col  = c;
        e.last = last;
        return e;
    endfunction

    task automatic do_start(input int w, input int h);
        @(negedge clk);
        cfg_width  = CW'(w);
        cfg_height = CW'(h);
        start      = 1'b1;
        s_valid    = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL start_busy: got %b want 1", busy);
        end
    endtask

    // Streams a w x h frame (w, h already clamped). mode 1 toggles m_ready
    // 1,0,0,1. limit < w*h stops right after that many accepts.
    task automatic run_frame(input int w, input int h, input int base, input int mode,
                             input int exp_out, input int limit);
        int total = w * h;
        int stop  = (limit < total) ? limit : total;
        int sent  = 0;
        int pr    = 0;
        int pc    = 0;
        int outs  = 0;
        int cyc   = 0;
        bit done  = 1'b0;
        exp_t e;
        while (!done) begin
            @(negedge clk);
            cyc++;
            m_ready = (mode == 0) ? 1'b1 : ((cyc % 4 == 1) || (cyc % 4 == 0));
            s_valid = (sent < stop);
            s_data  = pix(base, pr, pc);
            #1;
            if (m_valid && !m_ready) begin
                n_checks++;
                if (s_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL stall_s_ready: got %b want 0", s_ready);
                end
            end
            if (m_valid) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_output: got row %0d col %0d data %h, want none",
                             m_row, m_col, m_data);
                end else begin
                    e = q[0];
                    if ({m_data, m_col, m_row, m_last} !== {e.data, CW'(e.col), CW'(e.row), e.last}) begin
                        n_fail++;
                        $display("FAIL column: got data %h col %0d row %0d last %b, want data %h col %0d row %0d last %b",
                                 m_data, m_col, m_row, m_last, e.data, e.col, e.row, e.last);
                    end
                    if (m_ready) begin
                        void'(q.pop_front());
                        outs++;
                    end
                end
            end
            if (s_valid && s_ready) begin
                if (emits(pr))
                    q.push_back(make_exp(base, pr, pc, (pr == h - 1) && (pc == w - 1)));
                sent++;
                if (pc == w - 1) begin
                    pc = 0;
                    pr++;
                end else begin
                    pc++;
                end
            end
            if (sent == stop && (stop < total || q.size() == 0))
                done = 1'b1;
            if (cyc > 3000) begin
                n_fail++;
                $display("FAIL timeout: got %0d accepts want %0d", sent, stop);
                done = 1'b1;
            end
        end
        if (stop == total) begin
            @(negedge clk);
            s_valid = 1'b0;
            #1;
            n_checks++;
            if (outs !== exp_out) begin
                n_fail++;
                $display("FAIL output_count: got %0d want %0d", outs, exp_out);
            end
            n_checks++;
            if (busy !== 1'b0 || m_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL frame_end: got busy %b m_valid %b want 0 0", busy, m_valid);
            end
        end
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        start      = 1'b0;
        s_valid    = 1'b1;
        s_data     = '0;
        m_ready    = 1'b1;
        cfg_width  = '0;
        cfg_height = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
        n_checks++;
        if (m_data !== '0) begin n_fail++; $display("FAIL reset_m_data: got %h want 0", m_data); end
        n_checks++;
        if (m_col !== '0 || m_row !== '0 || m_last !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_coords: got col %0d row %0d last %b want 0 0 0", m_col, m_row, m_last);
        end
        n_checks++;
        if (busy !== 1'b0 || s_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: got busy %b s_ready %b want 0 0", busy, s_ready);
        end
        s_valid = 1'b0;
    endtask

    task automatic test_basic_frame();
        do_start(4, 4);
        run_frame(4, 4, 0, 0, emits(0) ? 16 : 8, 1 << 30);
    endtask

    task automatic test_backpressure();
        do_start(4, 4);
        run_frame(4, 4, 0, 1, emits(0) ? 16 : 8, 1 << 30);
    endtask

    task automatic test_width_one();
        do_start(1, 5);
        run_frame(1, 5, 0, 0, emits(0) ? 5 : 3, 1 << 30);
    endtask

    task automatic test_width_zero_clamp();
        do_start(0, 4);
        run_frame(1, 4, 3, 1, emits(0) ? 4 : 2, 1 << 30);
    endtask

    task automatic test_short_frame();
        do_start(2, 2);
        run_frame(2, 2, 0, 0, emits(0) ? 4 : 0, 1 << 30);
    endtask

    task automatic test_abort();
        do_start(8, 4);
        run_frame(8, 4, 'h100, 0, 0, 10);
        do_start(4, 3);
        n_checks++;
        if (m_valid !== 1'b0) begin n_fail++; $display("FAIL abort_m_valid: got %b want 0", m_valid); end
        q.delete();
        run_frame(4, 3, 0, 0, emits(0) ? 12 : 4, 1 << 30);
    endtask

    task automatic test_mid_reset();
        do_start(2, 4);
        run_frame(2, 4, 0, 0, 0, 5);
        @(negedge clk);
        s_valid = 1'b0;
        #1;
        n_checks++;
        if (m_valid !== 1'b1) begin n_fail++; $display("FAIL pre_reset_valid: got %b want 1", m_valid); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        s_valid = 1'b1;
        #1;
        n_checks++;
        if (m_valid !== 1'b0 || m_data !== '0 || m_col !== '0 || m_row !== '0 || m_last !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: got valid %b data %h col %0d row %0d last %b want all 0",
                     m_valid, m_data, m_col, m_row, m_last);
        end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_reset_busy: got %b want 0", busy); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            n_checks++;
            if (s_ready !== 1'b0) begin n_fail++; $display("FAIL mid_reset_s_ready: got %b want 0", s_ready); end
        end
        s_valid = 1'b0;
        q.delete();
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_backpressure();
        test_width_one();
        test_width_zero_clamp();
        test_short_frame();
        test_abort();
        test_mid_reset();
        test_basic_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
